// File: rtl/branch_target_predictor_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_target_predictor_if : fetch lookup, MEM-stage resolve and flush
// request bundle shared by the pipeline and the branch predictor.
// Revision 1.0
// ---------------------------------------------------------------------------
interface branch_target_predictor_if;
  logic        stall;
  logic [15:0] fetch_pc;
  logic        predict_taken;
  logic [15:0] predict_target;
  logic        resolve_valid;
  logic [15:0] resolve_pc;
  logic        resolve_taken;
  logic [15:0] resolve_target;
  logic        resolve_pred_taken;
  logic [15:0] resolve_pred_target;
  logic        mispredict;
  logic [15:0] correct_pc;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  modport master (
    output stall, fetch_pc,
    output resolve_valid, resolve_pc, resolve_taken, resolve_target,
    output resolve_pred_taken, resolve_pred_target,
    input  predict_taken, predict_target, mispredict, correct_pc,
    input  branch_count, mispredict_count
  );

  modport slave (
    input  stall, fetch_pc,
    input  resolve_valid, resolve_pc, resolve_taken, resolve_target,
    input  resolve_pred_taken, resolve_pred_target,
    output predict_taken, predict_target, mispredict, correct_pc,
    output branch_count, mispredict_count
  );
endinterface
`default_nettype wire

// File: rtl/branch_target_predictor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_target_predictor : direct-mapped BTB with 2-bit counters; predicts
// fetch next-PC and flags MEM-stage mispredicts.  Revision 1.0
// ---------------------------------------------------------------------------
module branch_target_predictor #(
  parameter int         INDEX_BITS = 4,
  parameter logic [1:0] CTR_INIT   = 2'b01
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  branch_target_predictor_if.slave  bp
);

  localparam int NUM_ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_BITS    = 15 - INDEX_BITS;

  logic [NUM_ENTRIES-1:0]               entry_valid;
  logic [NUM_ENTRIES-1:0][TAG_BITS-1:0] entry_tag;
  logic [NUM_ENTRIES-1:0][15:0]         entry_target;
  logic [NUM_ENTRIES-1:0][1:0]          entry_ctr;

  logic [INDEX_BITS-1:0] fetch_idx;
  logic [TAG_BITS-1:0]   fetch_tag;
  logic                  fetch_hit;
  logic [INDEX_BITS-1:0] res_idx;
  logic [TAG_BITS-1:0]   res_tag;
  logic                  res_hit;
  logic                  update_en;
  logic                  target_wrong;

  logic [15:0] branch_count_q, branch_count_d;
  logic [15:0] mispredict_count_q, mispredict_count_d;

  assign fetch_idx = bp.fetch_pc[INDEX_BITS:1];
  assign fetch_tag = bp.fetch_pc[15:INDEX_BITS+1];
  assign res_idx   = bp.resolve_pc[INDEX_BITS:1];
  assign res_tag   = bp.resolve_pc[15:INDEX_BITS+1];
  assign update_en = bp.resolve_valid && !bp.stall;

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign fetch_hit = entry_valid[fetch_idx] && (entry_tag[fetch_idx] == fetch_tag);
  assign res_hit   = entry_valid[res_idx] && (entry_tag[res_idx] == res_tag);

  assign bp.predict_taken  = fetch_hit && entry_ctr[fetch_idx][1];
  assign bp.predict_target = bp.predict_taken ? entry_target[fetch_idx]
                                              : bp.fetch_pc + 16'd2;

  assign target_wrong  = bp.resolve_taken && (bp.resolve_target != bp.resolve_pred_target);
  assign bp.mispredict = update_en &&
                         ((bp.resolve_taken != bp.resolve_pred_taken) || target_wrong);
  assign bp.correct_pc = bp.resolve_taken ? bp.resolve_target : bp.resolve_pc + 16'd2;

  generate
    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
      logic                valid_q,  valid_d;
      logic [TAG_BITS-1:0] tag_q,    tag_d;
      logic [15:0]         target_q, target_d;
      logic [1:0]          ctr_q,    ctr_d;
      logic                sel;

      assign sel = update_en && (res_idx == INDEX_BITS'(i));

      always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (sel) begin
          if (res_hit) begin
            if (bp.resolve_taken) begin
              ctr_d    = (ctr_q == 2'b11) ? 2'b11 : ctr_q + 2'b01;
              target_d = bp.resolve_target;
            end else begin
              ctr_d    = (ctr_q == 2'b00) ? 2'b00 : ctr_q - 2'b01;
            end
          end else if (bp.resolve_taken) begin
            // Direct-mapped: a taken miss evicts whatever lives at this index.
            valid_d  = 1'b1;
            tag_d    = res_tag;
            target_d = bp.resolve_target;
            ctr_d    = 2'b10;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          valid_q  <= 1'b0;
          tag_q    <= '0;
          target_q <= '0;
          ctr_q    <= CTR_INIT;
        end else begin
          valid_q  <= valid_d;
          tag_q    <= tag_d;
          target_q <= target_d;
          ctr_q    <= ctr_d;
        end
      end

      assign entry_valid[i]  = valid_q;
      assign entry_tag[i]    = tag_q;
      assign entry_target[i] = target_q;
      assign entry_ctr[i]    = ctr_q;
    end
  endgenerate

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (update_en) begin
      if (branch_count_q != 16'hFFFF) begin
        branch_count_d = branch_count_q + 16'd1;
      end
      if (bp.mispredict && (mispredict_count_q != 16'hFFFF)) begin
        mispredict_count_d = mispredict_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign bp.branch_count     = branch_count_q;
  assign bp.mispredict_count = mispredict_count_q;

endmodule
`default_nettype wire
